segasys1_sndcmd: RTL and testbench

Sound-command mailbox between the main CPU and the sound CPU. It queues each sound request (`SNDRQ` edge plus `SNDNO` byte) from the main-CPU block in a small FIFO. It then presents the commands one at a time to the sound CPU, raising an NMI of fixed width and waiting for the sound CPU to read the command port before releasing the slot. Unread commands are retried on timeout, and overflow is flagged. The block sits between the main CPU subsystem and the sound CPU subsystem, entirely in the `CLK48M` domain.

---
 rtl/segasys1_sndcmd_pkg.sv | 28 ++
 rtl/segasys1_cmdfifo.sv | 63 ++++++
 rtl/segasys1_sndcmd.sv | 120 ++++++++++++
 tb/tb_segasys1_sndcmd.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/segasys1_sndcmd_pkg.sv
// Shared definitions for the sound-command mailbox.
//   state_e     : FSM encoding for presenting commands to the sound CPU.
//   *_LEN_DEF   : default NMI width, post-ack gap and retry timeout (CLK48M cycles).
//   cnt_width() : width of the shared down-counter, sized to the longest interval.
package segasys1_sndcmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_WAIT   = 2'd2,
      ST_GAP    = 2'd3
   } state_e;

   localparam int unsigned NMI_LEN_DEF = 64;
   localparam int unsigned GAP_LEN_DEF = 32;
   localparam int unsigned TMO_LEN_DEF = 48000;

   // Bits needed to hold max(a, b, c) - 1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/segasys1_cmdfifo.sv
// 8-bit synchronous command FIFO, 2^DEPTH_LOG2 entries.
//   push_i/din_i : enqueue din_i (accepted when not full, or when full with a pop)
//   pop_i        : dequeue the head entry (ignored when empty)
//   head_o       : entry at the read pointer
//   count_o      : occupancy, 0..2^DEPTH_LOG2
//   full_o/empty_o : occupancy flags
module segasys1_cmdfifo #(
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [7:0]            din_i,
   output logic [7:0]            head_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;

   logic [7:0]            mem_q [Depth];
   logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   // Occupancy never exceeds Depth, so the MSB alone marks full.
   assign full_o  = count_q[DEPTH_LOG2];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rptr_q];

   assign do_pop  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= din_i;
   end

endmodule

// File: rtl/segasys1_sndcmd.sv
// Sound-command mailbox: main CPU -> FIFO -> sound CPU with NMI handshake.
//   CLK48M/RESETn : clock, async active-low reset
//   SNDRQ/SNDNO   : request (rising edge = one command) and command byte
//   SRD           : sound-CPU read strobe; rising edge acknowledges the presented command
//   SNMI          : NMI to the sound CPU, high for NMI_LEN cycles per (re)try
//   SCMD          : last command presented
//   SCNT          : FIFO occupancy
//   SOVF          : sticky overflow (push dropped on a full FIFO)
//   BUSY          : presenting or in the post-ack gap
module segasys1_sndcmd
   import segasys1_sndcmd_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 2,
   parameter int unsigned NMI_LEN    = NMI_LEN_DEF,
   parameter int unsigned GAP_LEN    = GAP_LEN_DEF,
   parameter int unsigned TMO_LEN    = TMO_LEN_DEF
) (
   input  logic                  CLK48M,
   input  logic                  RESETn,
   input  logic                  SNDRQ,
   input  logic [7:0]            SNDNO,
   input  logic                  SRD,
   output logic                  SNMI,
   output logic [7:0]            SCMD,
   output logic [DEPTH_LOG2:0]   SCNT,
   output logic                  SOVF,
   output logic                  BUSY
);

   localparam int unsigned CntW = cnt_width(NMI_LEN, GAP_LEN, TMO_LEN);
   localparam logic [CntW-1:0] NmiLoad = CntW'(NMI_LEN - 1);
   localparam logic [CntW-1:0] GapLoad = CntW'(GAP_LEN - 1);
   localparam logic [CntW-1:0] TmoLoad = CntW'(TMO_LEN - 1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        scmd_q, scmd_d;
   logic              sovf_q, sovf_d;
   logic              rq_q, rd_q;
   logic              push, ack, pop;
   logic [7:0]        fifo_head;
   logic              fifo_full, fifo_empty;

   assign push = SNDRQ & ~rq_q;
   assign ack  = SRD & ~rd_q;

   segasys1_cmdfifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk_i   (CLK48M),
      .rst_ni  (RESETn),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (SNDNO),
      .head_o  (fifo_head),
      .count_o (SCNT),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      scmd_d  = scmd_q;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               scmd_d  = fifo_head;
               cnt_d   = NmiLoad;
               state_d = ST_ASSERT;
            end
         end
         ST_ASSERT, ST_WAIT: begin
            if (ack) begin
               pop     = 1'b1;
               cnt_d   = GapLoad;
               state_d = ST_GAP;
            end else if (cnt_q == '0) begin
               // ASSERT times out into WAIT; WAIT times out into a retry of the same slot.
               cnt_d   = (state_q == ST_ASSERT) ? TmoLoad : NmiLoad;
               state_d = (state_q == ST_ASSERT) ? ST_WAIT : ST_ASSERT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign sovf_d = sovf_q | (push & fifo_full & ~pop);

   always_ff @(posedge CLK48M or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         scmd_q  <= 8'h00;
         sovf_q  <= 1'b0;
         rq_q    <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         scmd_q  <= scmd_d;
         sovf_q  <= sovf_d;
         rq_q    <= SNDRQ;
         rd_q    <= SRD;
      end
   end

   assign SNMI = (state_q == ST_ASSERT);
   assign BUSY = (state_q != ST_IDLE);
   assign SCMD = scmd_q;
   assign SOVF = sovf_q;

endmodule

// File: tb/tb_segasys1_sndcmd.sv
// Randomised bench for segasys1_sndcmd with a timeline-based reference model.
module tb_segasys1_sndcmd;

   localparam int unsigned DL    = 2;
   localparam int unsigned DEPTH = 1 << DL;
   localparam int unsigned NL    = 8;
   localparam int unsigned GL    = 4;
   localparam int unsigned TL    = 12;

   logic          CLK48M = 1'b0;
   logic          RESETn;
   logic          SNDRQ;
   logic [7:0]    SNDNO;
   logic          SRD;
   logic          SNMI;
   logic [7:0]    SCMD;
   logic [DL:0]   SCNT;
   logic          SOVF;
   logic          BUSY;

   int n_cmp  = 0;
   int n_fail = 0;

   segasys1_sndcmd #(
      .DEPTH_LOG2 (DL),
      .NMI_LEN    (NL),
      .GAP_LEN    (GL),
      .TMO_LEN    (TL)
   ) dut (
      .CLK48M (CLK48M),
      .RESETn (RESETn),
      .SNDRQ  (SNDRQ),
      .SNDNO  (SNDNO),
      .SRD    (SRD),
      .SNMI   (SNMI),
      .SCMD   (SCMD),
      .SCNT   (SCNT),
      .SOVF   (SOVF),
      .BUSY   (BUSY)
   );

   always #5 CLK48M = ~CLK48M;

   // ---------------- reference model ----------------
   // A command being presented started at edge t0; SNMI follows a fixed
   // NL-high / TL-low cycle from there until acknowledged. After an ack the
   // block stays busy for GL edges, then idles.
   logic [7:0]  mq[$];
   bit          m_ovf  = 0;
   bit          m_pres = 0;
   bit          m_gap  = 0;
   bit          prq    = 0;
   bit          prd    = 0;
   int unsigned cyc    = 0;
   int unsigned t0     = 0;
   int unsigned gend   = 0;
   logic [7:0]  m_scmd = 8'h00;
   bit          m_push, m_ack, m_pop, m_fullb;
   int          m_szb;

   always @(posedge CLK48M) begin
      if (!RESETn) begin
         mq.delete();
         m_ovf = 0; m_pres = 0; m_gap = 0; prq = 0; prd = 0;
         cyc = 0; m_scmd = 8'h00;
      end else begin
         cyc++;
         m_push = SNDRQ && !prq;
         m_ack  = SRD && !prd;
         prq = SNDRQ;
         prd = SRD;
         m_szb   = mq.size();
         m_fullb = (m_szb == DEPTH);
         m_pop   = m_pres && m_ack;
         if (m_pres) begin
            if (m_ack) begin
               m_pres = 0; m_gap = 1; gend = cyc + GL;
            end
         end else if (m_gap) begin
            if (cyc == gend) m_gap = 0;
         end else if (m_szb != 0) begin
            m_pres = 1; t0 = cyc; m_scmd = mq[0];
         end
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            if (m_fullb && !m_pop) m_ovf = 1;
            else mq.push_back(SNDNO);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [12+DL:0] exp_v, got_v;
   bit             e_nmi;

   always @(negedge CLK48M) begin
      if (RESETn !== 1'b1) begin
         exp_v = '0;
      end else begin
         e_nmi = m_pres && (((cyc - t0) % (NL + TL)) < NL);
         exp_v = {e_nmi, m_scmd, (DL+1)'(mq.size()), m_ovf, (m_pres || m_gap)};
      end
      got_v = {SNMI, SCMD, SCNT, SOVF, BUSY};
      n_cmp++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL cycle_outputs @%0d {snmi,scmd,scnt,sovf,busy}: got %h want %h",
                  cyc, got_v, exp_v);
      end
   end

   // ---------------- stimulus ----------------
   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge CLK48M);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      SNDRQ  = 1'b0;
      SRD    = 1'b0;
      RESETn = 1'b0;
      #1;
      check("reset_snmi", SNMI, 0);
      check("reset_scnt", SCNT, 0);
      check("reset_busy", BUSY, 0);
      check("reset_scmd", SCMD, 0);
      ticks(2);
      RESETn = 1'b1;
      tick();
   endtask

   task automatic run_random(input int cycles, input int p_rq, input int p_rd,
                             input bit allow_rst);
      for (int i = 0; i < cycles; i++) begin
         if (SNDRQ) begin
            if ($urandom_range(1, 0) == 1) SNDRQ = 1'b0;
         end else if (int'($urandom_range(99, 0)) < p_rq) begin
            SNDRQ = 1'b1;
            SNDNO = 8'($urandom);
         end
         if (SRD) begin
            if ($urandom_range(1, 0) == 1) SRD = 1'b0;
         end else if (int'($urandom_range(99, 0)) < p_rd) begin
            SRD = 1'b1;
         end
         if (allow_rst && $urandom_range(599, 0) == 0) do_reset();
         else tick();
      end
   endtask

   initial begin
      RESETn = 1'b0;
      SNDRQ  = 1'b0;
      SNDNO  = 8'h00;
      SRD    = 1'b0;
      ticks(3);
      RESETn = 1'b1;
      tick();
      check("idle_scnt", SCNT, 0);
      check("idle_busy", BUSY, 0);

      // Single command 5A: count at edge n, NMI from edge n+1 for NL cycles.
      SNDRQ = 1'b1; SNDNO = 8'h5A;
      tick();
      check("single_scnt_n", SCNT, 1);
      check("single_snmi_n", SNMI, 0);
      SNDRQ = 1'b0;
      tick();
      check("single_snmi_n1", SNMI, 1);
      check("single_scmd", SCMD, 8'h5A);
      ticks(NL - 1);
      check("single_snmi_last", SNMI, 1);
      tick();
      check("single_wait_snmi", SNMI, 0);
      check("single_wait_busy", BUSY, 1);
      SRD = 1'b1;
      tick();
      check("ack_scnt", SCNT, 0);
      SRD = 1'b0;
      ticks(GL - 1);
      check("gap_busy", BUSY, 1);
      tick();
      check("gap_done_busy", BUSY, 0);
      ticks(3);

      // Overflow: five pushes, no ack; then push together with a pop while full.
      for (int i = 0; i < 5; i++) begin
         SNDRQ = 1'b1; SNDNO = 8'(8'h10 + i);
         tick();
         SNDRQ = 1'b0;
         tick();
      end
      check("ovf_scnt", SCNT, 4);
      check("ovf_sovf", SOVF, 1);
      check("ovf_scmd", SCMD, 8'h10);
      SNDRQ = 1'b1; SNDNO = 8'h77; SRD = 1'b1;
      tick();
      check("full_pop_push_scnt", SCNT, 4);
      SNDRQ = 1'b0; SRD = 1'b0;
      ticks(GL + 1);
      check("next_scmd", SCMD, 8'h11);
      ticks(NL + TL + 4);

      // Reset during ASSERT with three commands queued.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         SNDRQ = 1'b1; SNDNO = 8'(8'hA0 + i);
         tick();
         SNDRQ = 1'b0;
         tick();
      end
      check("pre_rst_snmi", SNMI, 1);
      do_reset();
      ticks(20);
      check("post_rst_busy", BUSY, 0);
      check("post_rst_snmi", SNMI, 0);

      // Randomised traffic: heavy/no ack (retries, overflow), balanced, sparse, resets.
      run_random(1500, 30, 0, 1'b0);
      run_random(2000, 20, 10, 1'b1);
      run_random(2000, 5, 40, 1'b1);
      run_random(2000, 40, 5, 1'b1);
      SNDRQ = 1'b0; SRD = 1'b0;
      ticks(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
